// File: rtl/rcv_pkg.sv
// Shared types and default sizing for the receive buffer.
package rcv_pkg;

  typedef enum logic {ACCEPT = 1'b0, DISCARD = 1'b1} rcv_state_t;

  localparam int RCV_DATA_W = 8;
  localparam int RCV_DEPTH  = 16;
  localparam int RCV_DROP_W = 16;

endpackage

// File: rtl/rcv_fifo_mem.sv
// FIFO storage with a registered show-ahead read port.
// The read register is loaded with the word at raddr. When that same slot is
// being written this cycle, the incoming word is forwarded straight through.
module rcv_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DATA_W:0] wdata,
  input  logic            ld,
  input  logic [AW-1:0]   raddr,
  output logic [DATA_W:0] rdata
);

  logic [DATA_W:0] mem [DEPTH];

  // Storage array; it is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Head register; it holds its value whenever ld is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (ld) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/rcv_buf.sv
// Receive channel: a strobed word stream feeds a show-ahead FIFO. There is no
// input backpressure, so on overflow the rest of the offending frame is shed.
module rcv_buf
  import rcv_pkg::*;
#(
  parameter int DATA_W  = RCV_DATA_W,
  parameter int DEPTH   = RCV_DEPTH,
  parameter int DROP_W  = RCV_DROP_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rcv_in_vld,
  input  logic [DATA_W-1:0] rcv_in_data,
  input  logic              rcv_in_last,
  output logic              rcv_out_vld,
  input  logic              rcv_out_rdy,
  output logic [DATA_W-1:0] rcv_out_data,
  output logic              rcv_out_last,
  output logic [LVL_W-1:0]  rcv_level,
  output logic              rcv_ovf,
  input  logic              ovf_clr,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  rcv_state_t      state, state_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr, head_addr;
  logic [LVL_W-1:0] lvl_nxt;
  logic            pop, push, drop;
  logic [DATA_W:0] head;

  assign pop  = rcv_out_vld & rcv_out_rdy;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push = rcv_in_vld & (state == ACCEPT) &
                ((rcv_level < LVL_W'(DEPTH)) | pop);
  assign drop = rcv_in_vld & ~push;

  // The head slot for next cycle: it advances past the word being popped.
  assign head_addr = pop ? rd_ptr + AW'(1) : rd_ptr;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    lvl_nxt = rcv_level;
    if (push && !pop)      lvl_nxt = rcv_level + LVL_W'(1);
    else if (pop && !push) lvl_nxt = rcv_level - LVL_W'(1);
  end

  rcv_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({rcv_in_last, rcv_in_data}),
    .ld    (lvl_nxt != '0),
    .raddr (head_addr),
    .rdata (head)
  );

  assign rcv_out_vld  = (rcv_level != '0);
  assign rcv_out_data = head[DATA_W-1:0];
  assign rcv_out_last = head[DATA_W];

  // Pointers wrap modulo DEPTH. The level tracks push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rcv_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      rcv_level <= lvl_nxt;
    end
  end

  // Frame-drop FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCEPT;
    else     state <= state_nxt;
  end

  // Once a word is dropped mid-frame, discard everything up to and including
  // the frame end, so that no partial tail reaches the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT:  if (drop && !rcv_in_last)      state_nxt = DISCARD;
      DISCARD: if (rcv_in_vld && rcv_in_last) state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  // Sticky overflow flag and saturating drop count. A drop in the same cycle
  // as a clear wins, so that the new drop is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcv_ovf  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      rcv_ovf  <= 1'b1;
      if (ovf_clr)        drop_cnt <= DROP_W'(1);
      else if (~&drop_cnt) drop_cnt <= drop_cnt + DROP_W'(1);
    end else if (ovf_clr) begin
      rcv_ovf  <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
